alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter ROB_BITS, default 4, width of RoB entry tags.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rdy_in  input  1  global stall; low freezes all state.
REQ-005 SHALL have port clear_in  input  1  RoB mispredict flush.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1: operation handshake from reservation station.
REQ-007 SHALL have ports in_op input 6 {funct7 bit, funct3, type}; type 0=U, 1=I, 2=B, 3=R; 6'b111111=JAL.
REQ-008 SHALL have ports in_jalr input 1, in_vj input 32, in_vk input 32, in_imm input 32, in_pc input 32, in_id input ROB_BITS.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: result handshake to the CDB arbiter.
REQ-010 SHALL have ports out_id output ROB_BITS, out_value output 32, out_taken output 1, out_target output 32.

Function
REQ-011 SHALL accept an operation on a rising edge where in_valid, in_ready, rdy_in, rst_in high and clear_in low.
REQ-012 SHALL drive in_ready = rst_in && rdy_in && (entry count < DEPTH); no combinational path from out_ready.
REQ-013 SHALL compute at accept and write into a FIFO result queue; result visible on out_valid the following cycle (latency 1).
REQ-014 SHALL present the oldest queue entry on out_* whenever count > 0; out_valid = (count > 0).
REQ-015 SHALL pop the head on a rising edge with out_valid, out_ready, rdy_in high; simultaneous push and pop keeps count unchanged, order preserved.
REQ-016 U: value = in_imm (AUIPC sum pre-formed upstream); taken 0, target 0.
REQ-017 JAL (op 111111): value = pc+4; taken 1; target = pc+imm.
REQ-018 in_jalr=1 overrides op: value = pc+4; taken 1; target = (vj+imm) & ~1.
REQ-019 I: funct3 000 add, 010 slt signed, 011 sltu, 100 xor, 110 or, 111 and with imm; 001 sll, 101 srl (funct7 bit 0) / sra (bit 1) by imm[4:0].
REQ-020 R: as I using vk; 000 add/sub by funct7 bit; shifts by vk[4:0].
REQ-021 B: funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu on vj,vk; value = taken; target = pc+imm.
REQ-022 B funct3 010/011: value 0, taken 0, target 0; no error flag.
REQ-023 All arithmetic SHALL be 32-bit modulo 2^32; overflow discarded.
REQ-024 clear_in high on an edge (rdy_in high) SHALL empty the queue and discard any simultaneous input; out_valid 0 next cycle.
REQ-025 rdy_in low SHALL block accept, pop and clear; out_* held stable.
REQ-026 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While rst_in low at an edge: count, pointers cleared; out_valid 0, out_id 0, out_value 0, out_taken 0, out_target 0; in_ready 0 combinationally.
REQ-028 Reset SHALL take priority over clear_in and rdy_in; first accept possible on first edge after rst_in returns high.

Configuration
REQ-029 Macro ALU_OUTQ2_EN defined: DEPTH = 2, back-to-back accepts sustain one op per cycle with out_ready held high.
REQ-030 Macro ALU_OUTQ2_EN undefined: DEPTH = 1; in_ready low while entry held; max throughput one op per two cycles.

Verification
REQ-031 addi vj=5 imm=-7 id=3, out_ready=1 -> next cycle out_valid=1, out_id=3, out_value=0xFFFFFFFE, taken 0.
REQ-032 R sra (op funct7 bit 1, funct3 101) vj=0x80000000 vk=4 -> value 0xF8000000; srl same operands -> 0x08000000.
REQ-033 bltu vj=1 vk=0xFFFFFFFF pc=0x100 imm=0x20 -> taken 1, value 1, target 0x120; blt same operands -> taken 0.
REQ-034 jalr vj=0x1003 imm=2 pc=0x40 -> value 0x44, taken 1, target 0x1004.
REQ-035 ALU_OUTQ2_EN, out_ready=0, three ops offered -> two accepted, in_ready 0; raise out_ready -> results emitted in order, third accepted after first pop.
REQ-036 Queue holding 2 entries, clear_in pulse with in_valid=1 -> next cycle out_valid=0, count 0, offered op not emitted; rst_in low mid-operation -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_unit_if.sv
// Operation/result handshake bundle between the reservation station, the ALU and the CDB arbiter.
interface alu_unit_if #(
  parameter int ROB_BITS = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          in_op;
  logic                in_jalr;
  logic [31:0]         in_vj;
  logic [31:0]         in_vk;
  logic [31:0]         in_imm;
  logic [31:0]         in_pc;
  logic [ROB_BITS-1:0] in_id;

  logic                out_valid;
  logic                out_ready;
  logic [ROB_BITS-1:0] out_id;
  logic [31:0]         out_value;
  logic                out_taken;
  logic [31:0]         out_target;

  modport master (
    output in_valid, in_op, in_jalr, in_vj, in_vk, in_imm, in_pc, in_id,
    input  in_ready,
    input  out_valid, out_id, out_value, out_taken, out_target,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_jalr, in_vj, in_vk, in_imm, in_pc, in_id,
    output in_ready,
    output out_valid, out_id, out_value, out_taken, out_target,
    input  out_ready
  );
endinterface

// File: rtl/alu_unit.sv
// Single-cycle integer/branch ALU feeding a small result FIFO toward the CDB.
// Define ALU_OUTQ2_EN for a two-entry result queue; otherwise the queue holds one entry.
module alu_unit #(
  parameter int ROB_BITS = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      clear_in,
  alu_unit_if.slave bus
);
`ifdef ALU_OUTQ2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] TYPE_U = 2'd0;
  localparam logic [1:0] TYPE_I = 2'd1;
  localparam logic [1:0] TYPE_B = 2'd2;
  localparam logic [1:0] TYPE_R = 2'd3;
  localparam logic [5:0] OP_JAL = 6'b111111;

  typedef struct packed {
    logic [ROB_BITS-1:0] id;
    logic [31:0]         value;
    logic                taken;
    logic [31:0]         target;
  } res_t;

  logic [1:0]  op_type;
  logic [2:0]  funct3;
  logic        funct7_bit;
  logic [31:0] opnd_b;
  logic [4:0]  shamt;
  logic [31:0] alu_value;
  logic        br_taken;
  logic        br_valid;
  res_t        res;

  assign op_type    = bus.in_op[1:0];
  assign funct3     = bus.in_op[4:2];
  assign funct7_bit = bus.in_op[5];
  assign opnd_b     = (op_type == TYPE_R) ? bus.in_vk : bus.in_imm;
  assign shamt      = opnd_b[4:0];

  always_comb begin
    alu_value = '0;
    case (funct3)
      3'b000: alu_value = (op_type == TYPE_R && funct7_bit) ? bus.in_vj - opnd_b
                                                             : bus.in_vj + opnd_b;
      3'b001: alu_value = bus.in_vj << shamt;
      3'b010: alu_value = {31'b0, $signed(bus.in_vj) < $signed(opnd_b)};
      3'b011: alu_value = {31'b0, bus.in_vj < opnd_b};
      3'b100: alu_value = bus.in_vj ^ opnd_b;
      3'b101: alu_value = funct7_bit ? $unsigned($signed(bus.in_vj) >>> shamt)
                                     : bus.in_vj >> shamt;
      3'b110: alu_value = bus.in_vj | opnd_b;
      3'b111: alu_value = bus.in_vj & opnd_b;
      default: alu_value = '0;
    endcase
  end

  // funct3 010/011 are not branch encodings: they resolve as a quiet not-taken with zero target
  always_comb begin
    br_taken = 1'b0;
    br_valid = 1'b1;
    case (funct3)
      3'b000: br_taken = (bus.in_vj == bus.in_vk);
      3'b001: br_taken = (bus.in_vj != bus.in_vk);
      3'b100: br_taken = ($signed(bus.in_vj) <  $signed(bus.in_vk));
      3'b101: br_taken = ($signed(bus.in_vj) >= $signed(bus.in_vk));
      3'b110: br_taken = (bus.in_vj <  bus.in_vk);
      3'b111: br_taken = (bus.in_vj >= bus.in_vk);
      default: br_valid = 1'b0;
    endcase
  end

  always_comb begin
    res    = '0;
    res.id = bus.in_id;
    if (bus.in_jalr) begin
      res.value  = bus.in_pc + 32'd4;
      res.taken  = 1'b1;
      res.target = (bus.in_vj + bus.in_imm) & ~32'd1;
    end else if (bus.in_op == OP_JAL) begin
      res.value  = bus.in_pc + 32'd4;
      res.taken  = 1'b1;
      res.target = bus.in_pc + bus.in_imm;
    end else begin
      case (op_type)
        TYPE_U: res.value = bus.in_imm;
        TYPE_I,
        TYPE_R: res.value = alu_value;
        TYPE_B: begin
          res.value  = {31'b0, br_taken};
          res.taken  = br_taken;
          res.target = br_valid ? bus.in_pc + bus.in_imm : 32'd0;
        end
        default: res.value = '0;
      endcase
    end
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  res_t             mem_q [DEPTH];
  res_t             mem_d [DEPTH];
  res_t             head;
  logic             push;
  logic             pop;
  logic             do_clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready deliberately ignores out_ready: a full queue stalls even while popping
  assign bus.in_ready = rst_in && rdy_in && (count_q < CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && !clear_in;
  assign pop          = bus.out_valid && bus.out_ready && rdy_in && rst_in;
  assign do_clear     = clear_in && rdy_in;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = res;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; outputs are masked whenever the queue is empty
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_id     = bus.out_valid ? head.id     : '0;
  assign bus.out_value  = bus.out_valid ? head.value  : '0;
  assign bus.out_taken  = bus.out_valid ? head.taken  : 1'b0;
  assign bus.out_target = bus.out_valid ? head.target : '0;
endmodule

// File: tb/tb_alu_unit.sv
// Randomized bench for alu_unit against a queue-based behavioural model, plus directed corner cases.
module tb_alu_unit;
`ifdef ALU_OUTQ2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [3:0]  id;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  logic clk;
  logic rst_in, rdy_in, clear_in;
  int   n_total = 0;
  int   n_bad   = 0;

  logic        s_rst, s_rdy, s_clear, s_valid, s_jalr, s_out_ready;
  logic [5:0]  s_op;
  logic [31:0] s_vj, s_vk, s_imm, s_pc;
  logic [3:0]  s_id;

  exp_t model_q[$];

  alu_unit_if #(.ROB_BITS(4)) bus ();

  alu_unit #(.ROB_BITS(4)) dut (
    .clk_in  (clk),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .clear_in(clear_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference semantics from plain integer arithmetic
  function automatic exp_t ref_exec(input logic [5:0] op, input logic jalr,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [3:0] id);
    exp_t        r;
    logic [31:0] rhs;
    longint      ua, urhs, sa, srhs, sb, pow;
    int          sh;
    r.id = id; r.value = 0; r.taken = 0; r.target = 0;
    if (jalr) begin
      r.value  = 32'(longint'(pc) + 4);
      r.taken  = 1;
      r.target = 32'((longint'(a) + longint'(imm)) / 2 * 2);
      return r;
    end
    if (op == 6'd63) begin
      r.value  = 32'(longint'(pc) + 4);
      r.taken  = 1;
      r.target = 32'(longint'(pc) + longint'(imm));
      return r;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    case (op[1:0])
      2'd0: r.value = imm;
      2'd2: begin
        case (op[4:2])
          3'd0: r.taken = (a == b);
          3'd1: r.taken = (a != b);
          3'd4: r.taken = (sa < sb);
          3'd5: r.taken = (sa >= sb);
          3'd6: r.taken = (ua < longint'(b));
          3'd7: r.taken = (ua >= longint'(b));
          default: r.taken = 0;
        endcase
        r.value  = r.taken ? 1 : 0;
        r.target = (op[4:2] == 3'd2 || op[4:2] == 3'd3) ? 32'd0 : 32'(longint'(pc) + longint'(imm));
      end
      default: begin
        rhs  = (op[1:0] == 2'd3) ? b : imm;
        urhs = longint'(rhs);
        srhs = longint'($signed(rhs));
        sh   = int'(rhs % 32);
        pow  = longint'(1) << sh;
        case (op[4:2])
          3'd0: r.value = (op[1:0] == 2'd3 && op[5]) ? 32'(ua - urhs) : 32'(ua + urhs);
          3'd1: r.value = 32'(ua * pow);
          3'd2: r.value = (sa < srhs) ? 1 : 0;
          3'd3: r.value = (ua < urhs) ? 1 : 0;
          3'd4: r.value = a ^ rhs;
          3'd5: begin
            if (!op[5])      r.value = 32'(ua / pow);
            else if (sa < 0) r.value = 32'(-((-sa + pow - 1) / pow));
            else             r.value = 32'(sa / pow);
          end
          3'd6: r.value = a | rhs;
          default: r.value = a & rhs;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic check_outputs();
    exp_t h;
    chk("in_ready", 32'(bus.in_ready), 32'(s_rst && s_rdy && (model_q.size() < DEPTH)));
    chk("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) h = model_q[0];
    else begin h.id = 0; h.value = 0; h.taken = 0; h.target = 0; end
    chk("out_id", 32'(bus.out_id), 32'(h.id));
    chk("out_value", bus.out_value, h.value);
    chk("out_taken", 32'(bus.out_taken), 32'(h.taken));
    chk("out_target", bus.out_target, h.target);
  endtask

  task automatic model_edge();
    bit acc;
    if (!s_rst) model_q.delete();
    else if (s_rdy) begin
      if (s_clear) model_q.delete();
      else begin
        acc = s_valid && (model_q.size() < DEPTH);
        if (model_q.size() > 0 && s_out_ready) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_exec(s_op, s_jalr, s_vj, s_vk, s_imm, s_pc, s_id));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst_in = s_rst; rdy_in = s_rdy; clear_in = s_clear;
    bus.in_valid = s_valid; bus.in_op = s_op; bus.in_jalr = s_jalr;
    bus.in_vj = s_vj; bus.in_vk = s_vk; bus.in_imm = s_imm; bus.in_pc = s_pc;
    bus.in_id = s_id; bus.out_ready = s_out_ready;
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [5:0] op, input logic jalr,
                       input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] id,
                       input logic [31:0] e_value, input logic e_taken, input logic [31:0] e_target);
    s_rst = 1; s_rdy = 1; s_clear = 0; s_out_ready = 1;
    s_valid = 1; s_op = op; s_jalr = jalr; s_vj = vj; s_vk = vk; s_imm = imm; s_pc = pc; s_id = id;
    step();
    s_valid = 0; s_jalr = 0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.out_id), 32'(id));
    chk({tag, "_value"}, bus.out_value, e_value);
    chk({tag, "_taken"}, 32'(bus.out_taken), 32'(e_taken));
    chk({tag, "_target"}, bus.out_target, e_target);
    step();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    s_rst = 0; s_rdy = 1; s_clear = 0; s_valid = 0; s_jalr = 0; s_out_ready = 0;
    s_op = 0; s_vj = 0; s_vk = 0; s_imm = 0; s_pc = 0; s_id = 0;
    rst_in = 0; rdy_in = 1; clear_in = 0;
    bus.in_valid = 0; bus.in_op = 0; bus.in_jalr = 0; bus.in_vj = 0; bus.in_vk = 0;
    bus.in_imm = 0; bus.in_pc = 0; bus.in_id = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    step();
    step();

    issue("addi", 6'b000001, 0, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 4'd3, 32'hFFFF_FFFE, 0, 32'd0);
    issue("sra", 6'b110111, 0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd4, 32'hF800_0000, 0, 32'd0);
    issue("srl", 6'b010111, 0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd5, 32'h0800_0000, 0, 32'd0);
    issue("bltu", 6'b011010, 0, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd6, 32'd1, 1, 32'h120);
    issue("blt", 6'b010010, 0, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd7, 32'd0, 0, 32'h120);
    issue("jalr", 6'b000001, 1, 32'h1003, 32'd0, 32'd2, 32'h40, 4'd8, 32'h44, 1, 32'h1004);
    issue("jal", 6'b111111, 0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h200, 4'd9, 32'h204, 1, 32'h1F0);
    issue("b010", 6'b001010, 0, 32'd3, 32'd3, 32'h20, 32'h100, 4'd10, 32'd0, 0, 32'd0);
    issue("sub", 6'b100011, 0, 32'd0, 32'd1, 32'd0, 32'd0, 4'd11, 32'hFFFF_FFFF, 0, 32'd0);
    issue("lui", 6'b000000, 0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd12, 32'h1234_5000, 0, 32'd0);

    // Back-pressure: three offers with out_ready low, then drain in order
    s_out_ready = 0; s_valid = 1; s_op = 6'b000001; s_vj = 32'd10; s_imm = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      s_id = 4'(i);
      step();
    end
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_id", 32'(bus.out_id), 32'd1);
    s_out_ready = 1;
    repeat (5) step();
    s_valid = 0;
    repeat (3) step();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Flush with a simultaneous offer
    s_out_ready = 0; s_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      s_id = 4'(i + 2);
      step();
    end
    chk("pre_clr_valid", 32'(bus.out_valid), 32'd1);
    s_clear = 1; s_id = 4'd15;
    step();
    s_clear = 0; s_valid = 0;
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("clr_stays_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation
    s_valid = 1; s_id = 4'd6; s_op = 6'b111111; s_pc = 32'h300;
    step();
    s_rst = 0;
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);
    chk("rst_value", bus.out_value, 32'd0);
    chk("rst_taken", 32'(bus.out_taken), 32'd0);
    chk("rst_target", bus.out_target, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    s_rst = 1;
    step();
    chk("rst_first_accept", 32'(bus.out_valid), 32'd1);
    s_valid = 0; s_out_ready = 1;
    step();

    for (int n = 0; n < 3000; n++) begin
      s_rst       = ($urandom_range(0, 99) >= 2);
      s_rdy       = ($urandom_range(0, 99) < 85);
      s_clear     = ($urandom_range(0, 99) < 5);
      s_valid     = ($urandom_range(0, 99) < 70);
      s_out_ready = ($urandom_range(0, 99) < 60);
      s_jalr      = ($urandom_range(0, 9) == 0);
      s_op        = ($urandom_range(0, 9) == 0) ? 6'b111111 : 6'($urandom);
      s_vj        = rand_word();
      s_vk        = rand_word();
      s_imm       = rand_word();
      s_pc        = $urandom;
      s_id        = 4'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
